id_ex_fwd_pipe: RTL and testbench
=================================

Name: id_ex_fwd_pipe

Overview:
- Parametrised ID/EX pipeline register with generalised operand forwarding.
- Sits between the decode stage and the execute stage.
- Carries N source operands through an M-deep forwarding network with fixed priority.
- Detects load-use hazards, self-inserts bubbles, and holds on stall instead of inserting a NOP. Counts bubble cycles for performance monitoring.

Parameters:
DATA_W  32  operand/data width
ADDR_W  5  register address width
NUM_SRC  2  source operands per instruction
FWD_DEPTH  2  producer stages forwarded; index 0 = youngest (EX), 1 = MEM, ...
CTRL_W  16  packed decode control (aluop, alusel, misc) width
CNT_W  16  bubble counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
stall_i  in  1  EX stalled: hold all outputs
flush_i  in  1  exception flush: load NOP
id_valid_i  in  1  ID holds a valid instruction
id_ctrl_i  in  CTRL_W  decode control bundle
id_pc_i  in  DATA_W  instruction address
id_excepttype_i  in  DATA_W  exception type bits
id_wd_i  in  ADDR_W  destination register
id_wreg_i  in  1  destination write enable
id_src_rd_i  in  NUM_SRC  per-source read enable (0 = use immediate)
id_src_addr_i  in  NUM_SRC*ADDR_W  source register addresses, src k at bits [k*ADDR_W +: ADDR_W]
id_rf_data_i  in  NUM_SRC*DATA_W  regfile read data
id_imm_i  in  DATA_W  extended immediate
fwd_we_i  in  FWD_DEPTH  producer write enables
fwd_addr_i  in  FWD_DEPTH*ADDR_W  producer destinations
fwd_data_i  in  FWD_DEPTH*DATA_W  producer results
fwd_ok_i  in  FWD_DEPTH  producer result available (0 for a load still in EX)
hazard_o  out  1  combinational load-use hazard; ID/IF must stall
ex_valid_o  out  1  EX instruction valid
ex_ctrl_o  out  CTRL_W  registered control
ex_pc_o  out  DATA_W  registered instruction address
ex_excepttype_o  out  DATA_W  registered exception type
ex_wd_o  out  ADDR_W  registered destination
ex_wreg_o  out  1  registered write enable
ex_src_o  out  NUM_SRC*DATA_W  resolved operands
bubble_cnt_o  out  CNT_W  saturating count of bubble cycles

Behaviour:
- Reset: every output register is 0 immediately on rst rising, independent of clk. ctrl=0 encodes NOP. bubble_cnt_o=0.
- Operand resolution per source k (combinational, captured at clk edge):
  - Scan stages j=0..FWD_DEPTH-1; the first j with fwd_we_i[j]=1, fwd_addr_i[j]==src addr, src addr!=0 and id_src_rd_i[k]=1 wins.
  - Winner with fwd_ok_i[j]=1: operand = fwd_data_i[j].
  - No winner: operand = id_rf_data_i[k] if id_src_rd_i[k]=1, else id_imm_i.
  - Register 0 is never forwarded.
- hazard_o = id_valid_i & (some source's winner has fwd_ok_i=0). An older stage never substitutes for a not-ready younger match.
- Register update priority per clk edge:
  1. flush_i: load NOP (valid=0, ctrl=0, wreg=0, wd=0, operands=0, pc=0, excepttype=0).
  2. stall_i: hold all registers. Flush overrides stall when both are asserted.
  3. hazard_o: load bubble (same values as NOP); bubble_cnt_o += 1.
  4. Otherwise: load ID values and resolved operands; ex_valid_o=id_valid_i.
- id_valid_i=0 with no flush/stall loads NOP-equivalent control; this does not count as a bubble.
- Latency: 1 cycle, ID to EX outputs.
- bubble_cnt_o saturates at all-ones; it does not increment while stall_i or flush_i is active.
- Reset mid-stall clears state; the first post-reset edge follows the normal priority.

Test Plan:
- Reset: assert rst between edges with ex_src_o holding nonzero data -> all outputs 0 immediately, bubble_cnt_o=0.
- Stage priority: fwd stage0 we=1 addr=3 data=0x11 ok=1; stage1 we=1 addr=3 data=0x22; src0 addr=3 rd=1; rf=0x33 -> ex_src_o[src0]=0x11. With stage0 we=0 -> 0x22.
- Reg 0 and immediate: src1 addr=0 matching stage0 addr=0 data=0x55, rf=0 -> operand 0. Same source with rd=0, imm=0xFFFF_FFF0 -> operand 0xFFFF_FFF0.
- Load-use: stage0 we=1 addr=5 ok=0, src0 addr=5 rd=1, valid=1 -> hazard_o=1, next edge ex_valid_o=0, ctrl=0, bubble_cnt_o=1. Then ok=1 with data=0x77 -> instruction issues with operand 0x77.
- Stall/flush: load instruction pc=0x8000_0010, then stall_i=1 for 3 edges while ID inputs change -> outputs unchanged. Then stall_i=1 and flush_i=1 together -> NOP loaded, pc=0.
- Saturation: CNT_W=2, force 5 consecutive hazard cycles -> bubble_cnt_o reads 1,2,3,3,3.

Source files
------------

// File: rtl/id_ex_fwd_pipe_if.sv
// ID/EX boundary bundle: decode-side fields, producer forwarding taps and
// the registered EX-side view. The master drives ID/forwarding; the slave is the pipe.
interface id_ex_fwd_pipe_if #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 2,
  parameter int CTRL_W    = 16
);
  logic                          stall_i;
  logic                          flush_i;
  logic                          id_valid_i;
  logic [CTRL_W-1:0]             id_ctrl_i;
  logic [DATA_W-1:0]             id_pc_i;
  logic [DATA_W-1:0]             id_excepttype_i;
  logic [ADDR_W-1:0]             id_wd_i;
  logic                          id_wreg_i;
  logic [NUM_SRC-1:0]            id_src_rd_i;
  logic [NUM_SRC*ADDR_W-1:0]     id_src_addr_i;
  logic [NUM_SRC*DATA_W-1:0]     id_rf_data_i;
  logic [DATA_W-1:0]             id_imm_i;
  logic [FWD_DEPTH-1:0]          fwd_we_i;
  logic [FWD_DEPTH*ADDR_W-1:0]   fwd_addr_i;
  logic [FWD_DEPTH*DATA_W-1:0]   fwd_data_i;
  logic [FWD_DEPTH-1:0]          fwd_ok_i;
  logic                          hazard_o;
  logic                          ex_valid_o;
  logic [CTRL_W-1:0]             ex_ctrl_o;
  logic [DATA_W-1:0]             ex_pc_o;
  logic [DATA_W-1:0]             ex_excepttype_o;
  logic [ADDR_W-1:0]             ex_wd_o;
  logic                          ex_wreg_o;
  logic [NUM_SRC*DATA_W-1:0]     ex_src_o;

  modport master (
    output stall_i, flush_i, id_valid_i, id_ctrl_i, id_pc_i, id_excepttype_i,
           id_wd_i, id_wreg_i, id_src_rd_i, id_src_addr_i, id_rf_data_i, id_imm_i,
           fwd_we_i, fwd_addr_i, fwd_data_i, fwd_ok_i,
    input  hazard_o, ex_valid_o, ex_ctrl_o, ex_pc_o, ex_excepttype_o,
           ex_wd_o, ex_wreg_o, ex_src_o
  );

  modport slave (
    input  stall_i, flush_i, id_valid_i, id_ctrl_i, id_pc_i, id_excepttype_i,
           id_wd_i, id_wreg_i, id_src_rd_i, id_src_addr_i, id_rf_data_i, id_imm_i,
           fwd_we_i, fwd_addr_i, fwd_data_i, fwd_ok_i,
    output hazard_o, ex_valid_o, ex_ctrl_o, ex_pc_o, ex_excepttype_o,
           ex_wd_o, ex_wreg_o, ex_src_o
  );
endinterface

// File: rtl/id_ex_fwd_pipe.sv
// ID/EX pipeline register with multi-stage operand forwarding, load-use
// bubble insertion, hold-on-stall and a saturating bubble counter.
module id_ex_fwd_pipe #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 2,
  parameter int CTRL_W    = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  id_ex_fwd_pipe_if.slave  bus,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  logic [NUM_SRC*DATA_W-1:0] src_s;
  logic [NUM_SRC-1:0]        hit_s;
  logic [NUM_SRC-1:0]        wait_s;
  logic                      hazard_s;
  logic                      load_s;
  logic                      nop_s;
  logic                      bump_s;

  logic                      ex_valid_r;
  logic [CTRL_W-1:0]         ex_ctrl_r;
  logic [DATA_W-1:0]         ex_pc_r;
  logic [DATA_W-1:0]         ex_excepttype_r;
  logic [ADDR_W-1:0]         ex_wd_r;
  logic                      ex_wreg_r;
  logic [NUM_SRC*DATA_W-1:0] ex_src_r;
  logic [CNT_W-1:0]          bubble_cnt_r;

  // Operand resolution: youngest matching producer wins; a not-ready winner blocks older stages.
  always_comb begin
    src_s  = {(NUM_SRC*DATA_W){1'b0}};
    hit_s  = {NUM_SRC{1'b0}};
    wait_s = {NUM_SRC{1'b0}};
    for (int k = 0; k < NUM_SRC; k++) begin
      if (bus.id_src_rd_i[k]) begin
        src_s[k*DATA_W +: DATA_W] = bus.id_rf_data_i[k*DATA_W +: DATA_W];
      end else begin
        src_s[k*DATA_W +: DATA_W] = bus.id_imm_i;
      end
      for (int j = 0; j < FWD_DEPTH; j++) begin
        if (!hit_s[k] && bus.id_src_rd_i[k] && bus.fwd_we_i[j] &&
            (bus.id_src_addr_i[k*ADDR_W +: ADDR_W] != {ADDR_W{1'b0}}) &&
            (bus.fwd_addr_i[j*ADDR_W +: ADDR_W] == bus.id_src_addr_i[k*ADDR_W +: ADDR_W])) begin
          hit_s[k]  = 1'b1;
          wait_s[k] = ~bus.fwd_ok_i[j];
          if (bus.fwd_ok_i[j]) begin
            src_s[k*DATA_W +: DATA_W] = bus.fwd_data_i[j*DATA_W +: DATA_W];
          end else begin
            src_s[k*DATA_W +: DATA_W] = src_s[k*DATA_W +: DATA_W];
          end
        end else begin
          hit_s[k] = hit_s[k];
        end
      end
    end
    hazard_s = bus.id_valid_i & (|wait_s);
  end

  // Flush beats stall; bubbles and invalid ID slots both load an all-zero NOP.
  assign load_s = bus.flush_i | ~bus.stall_i;
  assign nop_s  = bus.flush_i | hazard_s | ~bus.id_valid_i;
  assign bump_s = ~bus.flush_i & ~bus.stall_i & hazard_s;

  // EX-side pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_r      <= 1'b0;
      ex_ctrl_r       <= {CTRL_W{1'b0}};
      ex_pc_r         <= {DATA_W{1'b0}};
      ex_excepttype_r <= {DATA_W{1'b0}};
      ex_wd_r         <= {ADDR_W{1'b0}};
      ex_wreg_r       <= 1'b0;
      ex_src_r        <= {(NUM_SRC*DATA_W){1'b0}};
    end else if (load_s) begin
      ex_valid_r      <= nop_s ? 1'b0 : bus.id_valid_i;
      ex_ctrl_r       <= nop_s ? {CTRL_W{1'b0}} : bus.id_ctrl_i;
      ex_pc_r         <= nop_s ? {DATA_W{1'b0}} : bus.id_pc_i;
      ex_excepttype_r <= nop_s ? {DATA_W{1'b0}} : bus.id_excepttype_i;
      ex_wd_r         <= nop_s ? {ADDR_W{1'b0}} : bus.id_wd_i;
      ex_wreg_r       <= nop_s ? 1'b0 : bus.id_wreg_i;
      ex_src_r        <= nop_s ? {(NUM_SRC*DATA_W){1'b0}} : src_s;
    end else begin
      ex_valid_r      <= ex_valid_r;
      ex_ctrl_r       <= ex_ctrl_r;
      ex_pc_r         <= ex_pc_r;
      ex_excepttype_r <= ex_excepttype_r;
      ex_wd_r         <= ex_wd_r;
      ex_wreg_r       <= ex_wreg_r;
      ex_src_r        <= ex_src_r;
    end
  end

  // Saturating bubble counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_r <= {CNT_W{1'b0}};
    end else if (bump_s && (bubble_cnt_r != {CNT_W{1'b1}})) begin
      bubble_cnt_r <= bubble_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      bubble_cnt_r <= bubble_cnt_r;
    end
  end

  assign bus.hazard_o        = hazard_s;
  assign bus.ex_valid_o      = ex_valid_r;
  assign bus.ex_ctrl_o       = ex_ctrl_r;
  assign bus.ex_pc_o         = ex_pc_r;
  assign bus.ex_excepttype_o = ex_excepttype_r;
  assign bus.ex_wd_o         = ex_wd_r;
  assign bus.ex_wreg_o       = ex_wreg_r;
  assign bus.ex_src_o        = ex_src_r;
  assign bubble_cnt_o        = bubble_cnt_r;

endmodule

// File: tb/tb_id_ex_fwd_pipe.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic compared each cycle against a behavioural model.
module tb_id_ex_fwd_pipe;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NS = 2;
  localparam int FD = 2;
  localparam int CW = 16;

  logic clk;
  logic rst;
  logic [15:0] cnt16;
  logic [1:0]  cnt2;
  int errors = 0;
  int checks = 0;

  id_ex_fwd_pipe_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_SRC(NS), .FWD_DEPTH(FD), .CTRL_W(CW)) bus ();
  id_ex_fwd_pipe_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_SRC(NS), .FWD_DEPTH(FD), .CTRL_W(CW)) bus2 ();

  id_ex_fwd_pipe #(.DATA_W(DW), .ADDR_W(AW), .NUM_SRC(NS), .FWD_DEPTH(FD), .CTRL_W(CW), .CNT_W(16))
    dut (.clk(clk), .rst(rst), .bus(bus), .bubble_cnt_o(cnt16));
  id_ex_fwd_pipe #(.DATA_W(DW), .ADDR_W(AW), .NUM_SRC(NS), .FWD_DEPTH(FD), .CTRL_W(CW), .CNT_W(2))
    dut_sat (.clk(clk), .rst(rst), .bus(bus2), .bubble_cnt_o(cnt2));

  // The narrow-counter instance sees exactly the same stimulus.
  assign bus2.stall_i = bus.stall_i;
  assign bus2.flush_i = bus.flush_i;
  assign bus2.id_valid_i = bus.id_valid_i;
  assign bus2.id_ctrl_i = bus.id_ctrl_i;
  assign bus2.id_pc_i = bus.id_pc_i;
  assign bus2.id_excepttype_i = bus.id_excepttype_i;
  assign bus2.id_wd_i = bus.id_wd_i;
  assign bus2.id_wreg_i = bus.id_wreg_i;
  assign bus2.id_src_rd_i = bus.id_src_rd_i;
  assign bus2.id_src_addr_i = bus.id_src_addr_i;
  assign bus2.id_rf_data_i = bus.id_rf_data_i;
  assign bus2.id_imm_i = bus.id_imm_i;
  assign bus2.fwd_we_i = bus.fwd_we_i;
  assign bus2.fwd_addr_i = bus.fwd_addr_i;
  assign bus2.fwd_data_i = bus.fwd_data_i;
  assign bus2.fwd_ok_i = bus.fwd_ok_i;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model state
  bit          exp_valid, exp_wreg;
  logic [15:0] exp_ctrl;
  logic [31:0] exp_pc, exp_exc;
  logic [4:0]  exp_wd;
  logic [63:0] exp_src;
  int          bubbles;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {not_ready, value}: first (youngest) matching producer decides.
  function automatic logic [DW:0] resolve(input int k);
    logic [AW-1:0] a;
    int win;
    a = bus.id_src_addr_i[k*AW +: AW];
    win = -1;
    if (bus.id_src_rd_i[k] && a != 5'd0)
      for (int j = FD - 1; j >= 0; j--)
        if (bus.fwd_we_i[j] && bus.fwd_addr_i[j*AW +: AW] == a) win = j;
    if (win < 0)
      return {1'b0, bus.id_src_rd_i[k] ? bus.id_rf_data_i[k*DW +: DW] : bus.id_imm_i};
    if (bus.fwd_ok_i[win]) return {1'b0, bus.fwd_data_i[win*DW +: DW]};
    return {1'b1, 32'h0};
  endfunction

  function automatic bit model_hazard();
    logic [DW:0] r;
    bit any;
    any = 1'b0;
    for (int k = 0; k < NS; k++) begin
      r = resolve(k);
      if (r[DW]) any = 1'b1;
    end
    return bus.id_valid_i && any;
  endfunction

  task automatic model_zero();
    exp_valid = 1'b0; exp_wreg = 1'b0; exp_ctrl = 16'h0; exp_pc = 32'h0;
    exp_exc = 32'h0; exp_wd = 5'd0; exp_src = 64'h0;
  endtask

  task automatic model_step();
    logic [DW:0] r;
    if (bus.flush_i) model_zero();
    else if (bus.stall_i) begin end
    else if (model_hazard()) begin model_zero(); bubbles++; end
    else if (!bus.id_valid_i) model_zero();
    else begin
      exp_valid = 1'b1; exp_wreg = bus.id_wreg_i; exp_ctrl = bus.id_ctrl_i;
      exp_pc = bus.id_pc_i; exp_exc = bus.id_excepttype_i; exp_wd = bus.id_wd_i;
      for (int k = 0; k < NS; k++) begin
        r = resolve(k);
        exp_src[k*DW +: DW] = r[DW-1:0];
      end
    end
  endtask

  task automatic compare_all();
    int c16, c2;
    c16 = (bubbles > 65535) ? 65535 : bubbles;
    c2  = (bubbles > 3) ? 3 : bubbles;
    check("hazard", {63'h0, bus.hazard_o}, {63'h0, model_hazard()});
    check("ex_valid", {63'h0, bus.ex_valid_o}, {63'h0, exp_valid});
    check("ex_ctrl", {48'h0, bus.ex_ctrl_o}, {48'h0, exp_ctrl});
    check("ex_pc", {32'h0, bus.ex_pc_o}, {32'h0, exp_pc});
    check("ex_exc", {32'h0, bus.ex_excepttype_o}, {32'h0, exp_exc});
    check("ex_wd", {59'h0, bus.ex_wd_o}, {59'h0, exp_wd});
    check("ex_wreg", {63'h0, bus.ex_wreg_o}, {63'h0, exp_wreg});
    check("ex_src", bus.ex_src_o, exp_src);
    check("bubble_cnt16", {48'h0, cnt16}, 64'(c16));
    check("sat_hazard", {63'h0, bus2.hazard_o}, {63'h0, model_hazard()});
    check("sat_valid", {63'h0, bus2.ex_valid_o}, {63'h0, exp_valid});
    check("sat_ctrl", {48'h0, bus2.ex_ctrl_o}, {48'h0, exp_ctrl});
    check("sat_pc", {32'h0, bus2.ex_pc_o}, {32'h0, exp_pc});
    check("sat_exc", {32'h0, bus2.ex_excepttype_o}, {32'h0, exp_exc});
    check("sat_wd", {59'h0, bus2.ex_wd_o}, {59'h0, exp_wd});
    check("sat_wreg", {63'h0, bus2.ex_wreg_o}, {63'h0, exp_wreg});
    check("sat_src", bus2.ex_src_o, exp_src);
    check("bubble_cnt2", {62'h0, cnt2}, 64'(c2));
  endtask

  // One clock: compare at the falling edge, advance the model, land #1 after the rising edge.
  task automatic cycle();
    @(negedge clk);
    compare_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    bus.stall_i = 1'b0; bus.flush_i = 1'b0; bus.id_valid_i = 1'b0;
    bus.id_ctrl_i = 16'h0; bus.id_pc_i = 32'h0; bus.id_excepttype_i = 32'h0;
    bus.id_wd_i = 5'd0; bus.id_wreg_i = 1'b0; bus.id_src_rd_i = 2'b00;
    bus.id_src_addr_i = 10'h0; bus.id_rf_data_i = 64'h0; bus.id_imm_i = 32'h0;
    bus.fwd_we_i = 2'b00; bus.fwd_addr_i = 10'h0; bus.fwd_data_i = 64'h0; bus.fwd_ok_i = 2'b11;
  endtask

  task automatic drive_rand();
    bus.stall_i = ($urandom_range(0, 7) == 0);
    bus.flush_i = ($urandom_range(0, 15) == 0);
    bus.id_valid_i = ($urandom_range(0, 7) != 0);
    bus.id_ctrl_i = 16'($urandom);
    bus.id_pc_i = $urandom;
    bus.id_excepttype_i = $urandom;
    bus.id_wd_i = 5'($urandom);
    bus.id_wreg_i = 1'($urandom);
    bus.id_src_rd_i = 2'($urandom);
    bus.id_imm_i = $urandom;
    bus.fwd_we_i = 2'($urandom);
    for (int k = 0; k < NS; k++) begin
      bus.id_src_addr_i[k*AW +: AW] = 5'($urandom_range(0, 3));
      bus.id_rf_data_i[k*DW +: DW] = $urandom;
    end
    for (int j = 0; j < FD; j++) begin
      bus.fwd_addr_i[j*AW +: AW] = 5'($urandom_range(0, 3));
      bus.fwd_data_i[j*DW +: DW] = $urandom;
      bus.fwd_ok_i[j] = ($urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    int sat_exp[5];
    sat_exp = '{1, 2, 3, 3, 3};
    rst = 1'b1;
    clr_inputs();
    model_zero();
    bubbles = 0;
    #1;
    check("reset_valid", {63'h0, bus.ex_valid_o}, 64'h0);
    check("reset_src", bus.ex_src_o, 64'h0);
    check("reset_cnt", {48'h0, cnt16}, 64'h0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Stage priority: youngest match wins, then the older stage when the young one is idle
    bus.id_valid_i = 1'b1; bus.id_ctrl_i = 16'h1234; bus.id_pc_i = 32'h100;
    bus.id_src_rd_i = 2'b11; bus.id_src_addr_i[4:0] = 5'd3; bus.id_rf_data_i[31:0] = 32'h33;
    bus.fwd_we_i = 2'b11; bus.fwd_addr_i = {5'd3, 5'd3};
    bus.fwd_data_i = {32'h22, 32'h11}; bus.fwd_ok_i = 2'b11;
    cycle();
    check("prio_stage0", {32'h0, bus.ex_src_o[31:0]}, 64'h11);
    check("prio_model", {32'h0, exp_src[31:0]}, 64'h11);
    bus.fwd_we_i = 2'b10;
    cycle();
    check("prio_stage1", {32'h0, bus.ex_src_o[31:0]}, 64'h22);

    // Register 0 never forwards; rd=0 selects the immediate
    bus.id_src_addr_i[9:5] = 5'd0; bus.id_rf_data_i[63:32] = 32'h0;
    bus.fwd_we_i = 2'b01; bus.fwd_addr_i[4:0] = 5'd0; bus.fwd_data_i[31:0] = 32'h55;
    cycle();
    check("reg0_operand", {32'h0, bus.ex_src_o[63:32]}, 64'h0);
    bus.id_src_rd_i[1] = 1'b0; bus.id_imm_i = 32'hFFFF_FFF0;
    cycle();
    check("imm_operand", {32'h0, bus.ex_src_o[63:32]}, 64'hFFFF_FFF0);

    // Load-use hazard, then issue once the load data is ready
    clr_inputs();
    bus.id_valid_i = 1'b1; bus.id_ctrl_i = 16'hABCD;
    bus.id_src_rd_i = 2'b01; bus.id_src_addr_i[4:0] = 5'd5;
    bus.fwd_we_i = 2'b01; bus.fwd_addr_i[4:0] = 5'd5; bus.fwd_ok_i = 2'b10;
    #1;
    check("loaduse_hazard", {63'h0, bus.hazard_o}, 64'h1);
    cycle();
    check("bubble_valid", {63'h0, bus.ex_valid_o}, 64'h0);
    check("bubble_ctrl", {48'h0, bus.ex_ctrl_o}, 64'h0);
    check("bubble_cnt", {48'h0, cnt16}, 64'h1);
    bus.fwd_ok_i = 2'b11; bus.fwd_data_i[31:0] = 32'h77;
    cycle();
    check("issue_valid", {63'h0, bus.ex_valid_o}, 64'h1);
    check("issue_operand", {32'h0, bus.ex_src_o[31:0]}, 64'h77);

    // Stall holds for 3 edges while ID changes; flush then overrides stall
    clr_inputs();
    bus.id_valid_i = 1'b1; bus.id_pc_i = 32'h8000_0010; bus.id_ctrl_i = 16'h0042;
    cycle();
    check("load_pc", {32'h0, bus.ex_pc_o}, 64'h8000_0010);
    bus.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.id_pc_i = $urandom; bus.id_ctrl_i = 16'($urandom);
      cycle();
      check("stall_pc", {32'h0, bus.ex_pc_o}, 64'h8000_0010);
      check("stall_ctrl", {48'h0, bus.ex_ctrl_o}, 64'h0042);
    end
    bus.flush_i = 1'b1;
    cycle();
    check("flush_pc", {32'h0, bus.ex_pc_o}, 64'h0);
    check("flush_valid", {63'h0, bus.ex_valid_o}, 64'h0);

    // Asynchronous reset mid-stall with nonzero operands held
    clr_inputs();
    bus.id_valid_i = 1'b1; bus.id_src_rd_i = 2'b11;
    bus.id_rf_data_i = {32'hCAFE_0002, 32'hCAFE_0001};
    cycle();
    check("pre_reset_src", bus.ex_src_o, 64'hCAFE_0002_CAFE_0001);
    bus.stall_i = 1'b1;
    cycle();
    #1 rst = 1'b1;
    #1;
    check("async_reset_src", bus.ex_src_o, 64'h0);
    check("async_reset_valid", {63'h0, bus.ex_valid_o}, 64'h0);
    check("async_reset_cnt", {48'h0, cnt16}, 64'h0);
    check("async_reset_cnt2", {62'h0, cnt2}, 64'h0);
    model_zero();
    bubbles = 0;
    #1 rst = 1'b0;
    bus.stall_i = 1'b0;
    cycle();
    check("post_reset_src", bus.ex_src_o, 64'hCAFE_0002_CAFE_0001);

    // Saturation of the 2-bit counter over 5 hazard cycles
    clr_inputs();
    bus.id_valid_i = 1'b1; bus.id_src_rd_i = 2'b01; bus.id_src_addr_i[4:0] = 5'd5;
    bus.fwd_we_i = 2'b01; bus.fwd_addr_i[4:0] = 5'd5; bus.fwd_ok_i = 2'b00;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("sat_cnt", {62'h0, cnt2}, 64'(sat_exp[i]));
    end

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      drive_rand();
      cycle();
    end
    @(negedge clk);
    compare_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
